// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/EX memory-port arbiter: requester ids, access sizes, lock states.
package mem_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_I = 2'd1,
        ST_LOCK_D = 2'd2
    } lock_state_t;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of requester ids for accepted-but-unanswered transactions (DEPTH power of 2).
module mem_arb_id_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_din,
    output logic o_head,
    output logic o_full,
    output logic o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    // Push is gated by the count at cycle start, so a full fifo never accepts even with a pop.
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between inst-fetch and data requesters with in-order response routing.
// Define MEM_ARB_RR_EN for round-robin arbitration in IDLE; default is fixed data priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [3:0]        d_wstrb,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [3:0]        m_wstrb,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              arb_err
);
    lock_state_t r_state, w_next;
    logic        w_gnt_vld;
    logic        w_gnt_id;
    logic        w_accept;
    logic        w_full;
    logic        w_empty;
    logic        w_head;
    logic        w_pop;
    logic        r_arb_err;
    logic        w_unused_iwr;

    // Instruction requests are always reads; the write flag is deliberately ignored.
    assign w_unused_iwr = i_wr;

`ifdef MEM_ARB_RR_EN
    logic r_rr_ptr;
`endif

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = ID_INST;
        w_next    = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_full) begin
                    if (d_req && i_req) begin
                        w_gnt_vld = 1'b1;
`ifdef MEM_ARB_RR_EN
                        w_gnt_id  = r_rr_ptr;
`else
                        w_gnt_id  = ID_DATA;
`endif
                    end else if (d_req) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = ID_DATA;
                    end else if (i_req) begin
                        w_gnt_vld = 1'b1;
                        w_gnt_id  = ID_INST;
                    end
                end
                if (w_gnt_vld && !m_addr_ok)
                    w_next = (w_gnt_id == ID_DATA) ? ST_LOCK_D : ST_LOCK_I;
            end
            ST_LOCK_I: begin
                w_gnt_id = ID_INST;
                if (!i_req) begin
                    w_next = ST_IDLE;
                end else begin
                    w_gnt_vld = !w_full;
                    if (m_addr_ok && !w_full)
                        w_next = ST_IDLE;
                end
            end
            ST_LOCK_D: begin
                w_gnt_id = ID_DATA;
                if (!d_req) begin
                    w_next = ST_IDLE;
                end else begin
                    w_gnt_vld = !w_full;
                    if (m_addr_ok && !w_full)
                        w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        m_req   = 1'b0;
        m_wr    = 1'b0;
        m_size  = '0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (w_gnt_vld) begin
            m_req = 1'b1;
            if (w_gnt_id == ID_DATA) begin
                m_wr    = d_wr;
                m_size  = d_size;
                m_wstrb = d_wstrb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                m_size  = i_size;
                m_addr  = i_addr;
            end
        end
    end

    assign w_accept  = m_req && m_addr_ok;
    assign i_addr_ok = w_accept && (w_gnt_id == ID_INST);
    assign d_addr_ok = w_accept && (w_gnt_id == ID_DATA);

    assign w_pop     = m_data_ok && !w_empty;
    assign i_data_ok = w_pop && (w_head == ID_INST);
    assign d_data_ok = w_pop && (w_head == ID_DATA);
    assign i_rdata   = i_data_ok ? m_rdata : '0;
    assign d_rdata   = d_data_ok ? m_rdata : '0;
    assign arb_err   = r_arb_err;

    mem_arb_id_fifo #(.DEPTH(MAX_OUT)) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_pop),
        .i_din   (w_gnt_id),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_arb_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (m_data_ok && w_empty)
                r_arb_err <= 1'b1;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_rr_ptr <= ID_INST;
        else if (w_accept)
            r_rr_ptr <= ~w_gnt_id;
    end
`endif

endmodule
